prog_loader: RTL

Program-memory loader for the multicycle RV64 core. It accepts an instruction image as a byte stream over a valid/ready handshake and assembles each group of four bytes into a 32-bit little-endian instruction. Each instruction is written into program memory at consecutive word addresses. The core is held in its stall state (`cpu_hold`) until the full image is written. The loader is the writer side of the program memory that the IF stage reads.

---
 rtl/prog_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program-memory loader: assembles a little-endian byte stream into 32-bit
// instructions, writes them at consecutive word addresses, and holds the core until done.
module prog_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        pm_we,
    output logic [63:0] pm_addr,
    output logic [31:0] pm_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  checksum_q, checksum_d;
    logic [63:0] pm_addr_q, pm_addr_d;
    logic [31:0] pm_wdata_q, pm_wdata_d;
    logic        byte_ready_q, pm_we_q, cpu_hold_q, busy_q, done_q, error_q;

    // Next-state and datapath update logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        checksum_d = checksum_q;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    word_idx_d = 16'd0;
                    byte_idx_d = 2'd0;
                    checksum_d = 8'd0;
                    cnt_d      = word_count;
                    if (word_count == 16'd0) begin
                        state_d = ST_DONE;
                    end else if ({16'd0, word_count} > DEPTH_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RECV: begin
                if (byte_valid) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
                    checksum_d = checksum_q + byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Address and word are captured here so they are stable for the whole WRITE cycle.
                        state_d    = ST_WRITE;
                        pm_addr_d  = BASE_ADDR + ({48'd0, word_idx_q} << 2);
                        pm_wdata_d = {byte_data, asm_q[23:0]};
                    end else begin
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                if ((word_idx_q + 16'd1) == cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            word_idx_q   <= 16'd0;
            byte_idx_q   <= 2'd0;
            asm_q        <= 32'd0;
            checksum_q   <= 8'd0;
            pm_addr_q    <= BASE_ADDR;
            pm_wdata_q   <= 32'd0;
            byte_ready_q <= 1'b0;
            pm_we_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            checksum_q   <= checksum_d;
            pm_addr_q    <= pm_addr_d;
            pm_wdata_q   <= pm_wdata_d;
            byte_ready_q <= (state_d == ST_RECV);
            pm_we_q      <= (state_d == ST_WRITE);
            cpu_hold_q   <= (state_d != ST_DONE);
            busy_q       <= (state_d == ST_RECV) || (state_d == ST_WRITE);
            done_q       <= (state_d == ST_DONE);
            error_q      <= (state_d == ST_ERR);
        end
    end

    assign byte_ready = byte_ready_q;
    assign pm_we      = pm_we_q;
    assign pm_addr    = pm_addr_q;
    assign pm_wdata   = pm_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign checksum   = checksum_q;

endmodule
